// File: rtl/spi_mem_slave_burst.sv
// SPI mode-0 slave with command/address/data framing and burst access to an internal RAM.
// Optional status command (8'h05) is built when SPI_STATUS_EN is defined.
module spi_mem_slave_burst #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CMD_W  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  output logic wr_pulse,
  output logic rd_pulse
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int MAX_AC = (CMD_W > ADDR_W) ? CMD_W : ADDR_W;
  localparam int SH_W   = (MAX_AC > DATA_W) ? MAX_AC : DATA_W;
  localparam int CNT_W  = $clog2(SH_W + 1);

  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CMD_W-1:0]  CMD_WRITE = CMD_W'(8'h02);
  localparam logic [CMD_W-1:0]  CMD_READ  = CMD_W'(8'h03);
`ifdef SPI_STATUS_EN
  localparam logic [CMD_W-1:0]  CMD_STATUS = CMD_W'(8'h05);
`endif

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_ADDR    = 3'd2;
  localparam logic [2:0] ST_WDATA   = 3'd3;
  localparam logic [2:0] ST_RDATA   = 3'd4;
  localparam logic [2:0] ST_DISCARD = 3'd5;
  localparam logic [2:0] ST_STATUS  = 3'd6;

  logic [2:0]        sclk_sync_r;
  logic [1:0]        cs_sync_r;
  logic [1:0]        mosi_sync_r;
  logic              sclk_rise_s;
  logic              sclk_fall_s;
  logic              cs_n_s;
  logic              mosi_s;

  logic [2:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [SH_W-2:0]   rx_r;
  logic [SH_W-1:0]   rx_next_s;
  logic [DATA_W-2:0] tx_r;
  logic [ADDR_W-1:0] addr_r;
  logic              is_wr_r;
  logic              word_done_r;
  logic [1:0]        load_dly_r;

  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] status_word_s;
  logic [DATA_W-1:0] load_word_s;
  logic              is_mem_s;

  logic              miso_r;
  logic              miso_oe_r;
  logic              busy_r;
  logic              wr_pulse_r;
  logic              rd_pulse_r;

  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
  assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
  assign cs_n_s      = cs_sync_r[1];
  assign mosi_s      = mosi_sync_r[1];
  assign rx_next_s   = {rx_r, mosi_s};

  assign is_mem_s    = (state_r == ST_RDATA);
  assign load_word_s = is_mem_s ? rdata_r : status_word_s;

  assign miso     = miso_r;
  assign miso_oe  = miso_oe_r;
  assign busy     = busy_r;
  assign wr_pulse = wr_pulse_r;
  assign rd_pulse = rd_pulse_r;

  // bring the SPI pins into the clk domain; mosi shares sclk's latency so samples line up
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_r <= 3'b000;
      cs_sync_r   <= 2'b11;
      mosi_sync_r <= 2'b00;
    end else begin
      sclk_sync_r <= {sclk_sync_r[1:0], sclk};
      cs_sync_r   <= {cs_sync_r[0], cs_n};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
    end
  end

  // frame sequencer: decodes command/address, drives write strobes and the miso shifter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      rx_r        <= '0;
      tx_r        <= '0;
      addr_r      <= '0;
      is_wr_r     <= 1'b0;
      word_done_r <= 1'b0;
      load_dly_r  <= 2'b00;
      we_r        <= 1'b0;
      waddr_r     <= '0;
      wdata_r     <= '0;
      miso_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
      busy_r      <= 1'b0;
      wr_pulse_r  <= 1'b0;
      rd_pulse_r  <= 1'b0;
    end else begin
      wr_pulse_r <= 1'b0;
      rd_pulse_r <= 1'b0;
      we_r       <= 1'b0;
      // chip select wins over any word completing in the same cycle
      if (cs_n_s) begin
        state_r     <= ST_IDLE;
        cnt_r       <= '0;
        word_done_r <= 1'b0;
        load_dly_r  <= 2'b00;
        miso_r      <= 1'b0;
        miso_oe_r   <= 1'b0;
        busy_r      <= 1'b0;
      end else begin
        busy_r <= 1'b1;
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_CMD;
            cnt_r   <= '0;
          end
          ST_CMD: begin
            if (sclk_rise_s) begin
              rx_r <= rx_next_s[SH_W-2:0];
              if (cnt_r == CMD_LAST) begin
                cnt_r <= '0;
                if (rx_next_s[CMD_W-1:0] == CMD_WRITE) begin
                  state_r <= ST_ADDR;
                  is_wr_r <= 1'b1;
                end else if (rx_next_s[CMD_W-1:0] == CMD_READ) begin
                  state_r <= ST_ADDR;
                  is_wr_r <= 1'b0;
`ifdef SPI_STATUS_EN
                end else if (rx_next_s[CMD_W-1:0] == CMD_STATUS) begin
                  state_r     <= ST_STATUS;
                  miso_oe_r   <= 1'b1;
                  load_dly_r  <= 2'b01;
                  word_done_r <= 1'b0;
`endif
                end else begin
                  state_r <= ST_DISCARD;
                end
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise_s) begin
              rx_r <= rx_next_s[SH_W-2:0];
              if (cnt_r == ADDR_LAST) begin
                cnt_r  <= '0;
                addr_r <= rx_next_s[ADDR_W-1:0];
                if (is_wr_r) begin
                  state_r <= ST_WDATA;
                end else begin
                  state_r     <= ST_RDATA;
                  miso_oe_r   <= 1'b1;
                  load_dly_r  <= 2'b01;
                  word_done_r <= 1'b0;
                end
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end
          end
          ST_WDATA: begin
            if (sclk_rise_s) begin
              rx_r <= rx_next_s[SH_W-2:0];
              if (cnt_r == DATA_LAST) begin
                cnt_r      <= '0;
                we_r       <= 1'b1;
                wr_pulse_r <= 1'b1;
                waddr_r    <= addr_r;
                wdata_r    <= rx_next_s[DATA_W-1:0];
                addr_r     <= addr_r + ADDR_ONE;
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end
          end
          // load_dly waits for the registered RAM read of a freshly set address
          ST_RDATA, ST_STATUS: begin
            load_dly_r <= {load_dly_r[0], 1'b0};
            if (load_dly_r[1] || (sclk_fall_s && word_done_r)) begin
              word_done_r <= 1'b0;
              tx_r        <= load_word_s[DATA_W-2:0];
              miso_r      <= load_word_s[DATA_W-1];
              if (is_mem_s) begin
                rd_pulse_r <= 1'b1;
                addr_r     <= addr_r + ADDR_ONE;
              end
            end else if (sclk_fall_s && (cnt_r != '0)) begin
              miso_r <= tx_r[DATA_W-2];
              tx_r   <= {tx_r[DATA_W-3:0], 1'b0};
            end
            if (sclk_rise_s) begin
              if (cnt_r == DATA_LAST) begin
                cnt_r       <= '0;
                word_done_r <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end
          end
          ST_DISCARD: begin
            state_r <= ST_DISCARD;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef SPI_STATUS_EN
  logic err_r;
  logic wr_done_r;

  assign status_word_s = {{(DATA_W-2){1'b0}}, err_r, wr_done_r};

  // sticky status bits, cleared when a status frame closes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r     <= 1'b0;
      wr_done_r <= 1'b0;
    end else if (cs_n_s && (state_r == ST_STATUS)) begin
      err_r     <= 1'b0;
      wr_done_r <= 1'b0;
    end else begin
      if (state_r == ST_DISCARD) begin
        err_r <= 1'b1;
      end
      if (we_r) begin
        wr_done_r <= 1'b1;
      end
    end
  end
`else
  assign status_word_s = '0;
`endif

  // RAM: single write port, registered read that always follows addr_r
  always_ff @(posedge clk) begin
    if (we_r) begin
      mem[waddr_r] <= wdata_r;
    end
    rdata_r <= mem[addr_r];
  end

endmodule
